// File: rtl/password_updater_pkg.sv
// Shared controller constants: password packing, RAM geometry and the
// updater state encoding. The password checker packs digits the same way.
package password_updater_pkg;

    localparam int PASS_W     = 24;
    localparam int DIGITS     = 6;
    localparam int DIGIT_W    = 4;
    localparam int CNT_W      = 3;
    localparam int PID_W      = 3;
    localparam int RAM_ADDR_W = 5;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE       = 4'd0;
    localparam state_t S_ENTER_NEW  = 4'd1;
    localparam state_t S_ENTER_CONF = 4'd2;
    localparam state_t S_COMPARE    = 4'd3;
    localparam state_t S_WRITE      = 4'd4;
    localparam state_t S_RD_ADDR    = 4'd5;
    localparam state_t S_RD_WAIT    = 4'd6;
    localparam state_t S_RD_CATCH   = 4'd7;
    localparam state_t S_VERIFY     = 4'd8;

    // BCD filter: nibbles above 9 are not digits.
    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

    // MSB-first packing: the earliest digit ends up in the top nibble.
    function automatic logic [PASS_W-1:0] shift_digit(input logic [PASS_W-1:0] w,
                                                      input logic [DIGIT_W-1:0] d);
        return {w[PASS_W-DIGIT_W-1:0], d};
    endfunction

endpackage

// File: rtl/password_updater_if.sv
// Password RAM port: the updater drives address/data/we, the RAM returns rdata.
interface password_updater_if
    import password_updater_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) ();
    logic [ADDR_W-1:0] RAM_addr;
    logic [PASS_W-1:0] RAM_wdata;
    logic              RAM_we;
    logic [PASS_W-1:0] RAM_rdata;

    modport master (output RAM_addr, RAM_wdata, RAM_we, input RAM_rdata);
    modport slave  (input RAM_addr, RAM_wdata, RAM_we, output RAM_rdata);
endinterface

// File: rtl/password_updater_pswd_digit_collector.sv
// Six-digit BCD collector. word_nxt is the word including the digit being
// accepted this cycle, so the owner can load it on the same edge full fires.
module pswd_digit_collector
    import password_updater_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    input  logic               strobe,
    input  logic [DIGIT_W-1:0] digit,
    output logic [PASS_W-1:0]  word_nxt,
    output logic               full
);
    logic [PASS_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    assign accept   = en && strobe && digit_ok(digit);
    assign full     = accept && (cnt_q == CNT_W'(DIGITS - 1));
    assign word_nxt = shift_digit(word_q, digit);

    // Shift accepted digits in; restart after the sixth so the next entry starts clean.
    always_ff @(posedge clk) begin
        if (!rst || clear || full) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            word_q <= word_nxt;
            cnt_q  <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/password_updater.sv
// Password change sequencer: collect new + confirm passwords, write the RAM
// at the player's ID, read it back after RD_LAT cycles and report the outcome.
module password_updater
    import password_updater_pkg::*;
#(
    parameter int RD_LAT = 3,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               loggedin,
    input  logic               isGuestIN,
    input  logic [PID_W-1:0]   internalPlayerIDIN,
    input  logic               b_change,
    input  logic               b_password,
    input  logic [DIGIT_W-1:0] passwordDigit,
    password_updater_if.master ram,
    output logic               busy,
    output logic               changeDone,
    output logic               changeFail
);
    localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    state_t            state, nxt;
    logic [PASS_W-1:0] new_pass, conf_pass, cap;
    logic [PID_W-1:0]  player_id;
    logic [WCW-1:0]    wait_cnt;
    logic [PASS_W-1:0] col_word;
    logic              col_full, col_en, can_change;

    logic [ADDR_W-1:0] addr_n;
    logic [PASS_W-1:0] wdata_n;
    logic              we_n, busy_n, done_n, fail_n;

    assign can_change = loggedin && !isGuestIN;
    assign col_en     = loggedin && (state == S_ENTER_NEW || state == S_ENTER_CONF);

    pswd_digit_collector u_col (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_IDLE),
        .en       (col_en),
        .strobe   (b_password),
        .digit    (passwordDigit),
        .word_nxt (col_word),
        .full     (col_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // Next state; logout aborts only before the write is issued.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:       if (b_change && can_change) nxt = S_ENTER_NEW;
            S_ENTER_NEW:  if (!loggedin) nxt = S_IDLE;
                          else if (col_full) nxt = S_ENTER_CONF;
            S_ENTER_CONF: if (!loggedin) nxt = S_IDLE;
                          else if (col_full) nxt = S_COMPARE;
            S_COMPARE:    nxt = (loggedin && new_pass == conf_pass) ? S_WRITE : S_IDLE;
            S_WRITE:      nxt = S_RD_ADDR;
            S_RD_ADDR:    nxt = (RD_LAT > 1) ? S_RD_WAIT : S_RD_CATCH;
            S_RD_WAIT:    if (wait_cnt == WCW'(RD_LAT - 2)) nxt = S_RD_CATCH;
            S_RD_CATCH:   nxt = S_VERIFY;
            S_VERIFY:     nxt = S_IDLE;
            default:      nxt = S_IDLE;
        endcase
    end

    // Next output values, derived from the state being entered so outputs can be registered.
    always_comb begin
        addr_n  = '0;
        wdata_n = '0;
        we_n    = 1'b0;
        busy_n  = (nxt != S_IDLE);
        done_n  = (state == S_VERIFY) && (cap == new_pass);
        fail_n  = ((state == S_IDLE) && b_change && !can_change)
               || ((state == S_COMPARE) && loggedin && (new_pass != conf_pass))
               || ((state == S_VERIFY) && (cap != new_pass));
        if (nxt inside {S_WRITE, S_RD_ADDR, S_RD_WAIT, S_RD_CATCH, S_VERIFY})
            addr_n = ADDR_W'(player_id);
        if (nxt == S_WRITE) begin
            wdata_n = new_pass;
            we_n    = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ram.RAM_addr  <= '0;
            ram.RAM_wdata <= '0;
            ram.RAM_we    <= 1'b0;
            busy          <= 1'b0;
            changeDone    <= 1'b0;
            changeFail    <= 1'b0;
        end else begin
            ram.RAM_addr  <= addr_n;
            ram.RAM_wdata <= wdata_n;
            ram.RAM_we    <= we_n;
            busy          <= busy_n;
            changeDone    <= done_n;
            changeFail    <= fail_n;
        end
    end

    // Datapath: session ID, both password words, readback capture and read-latency counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            new_pass  <= '0;
            conf_pass <= '0;
            cap       <= '0;
            player_id <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (b_change && can_change) begin
                    player_id <= internalPlayerIDIN;
                    new_pass  <= '0;
                    conf_pass <= '0;
                end
                S_ENTER_NEW:  if (col_full) new_pass  <= col_word;
                S_ENTER_CONF: if (col_full) conf_pass <= col_word;
                S_RD_ADDR:    wait_cnt <= '0;
                S_RD_WAIT:    wait_cnt <= wait_cnt + 1'b1;
                S_RD_CATCH:   cap      <= ram.RAM_rdata;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_password_updater.sv
// Bench for password_updater: directed sequences push expected RAM writes and
// done/fail pulses into a queue; a negedge monitor pops and compares them.
module tb_password_updater;
    import password_updater_pkg::*;

    localparam int RD_LAT = 3;
    localparam int ADDR_W = 5;

    logic        clk = 0, rst = 0, loggedin = 0, isGuestIN = 0;
    logic        b_change = 0, b_password = 0;
    logic [2:0]  pid = '0;
    logic [3:0]  digit = '0;
    logic        busy, changeDone, changeFail;
    logic        force_zero = 0;

    password_updater_if #(.ADDR_W(ADDR_W)) ram ();

    password_updater #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .loggedin           (loggedin),
        .isGuestIN          (isGuestIN),
        .internalPlayerIDIN (pid),
        .b_change           (b_change),
        .b_password         (b_password),
        .passwordDigit      (digit),
        .ram                (ram),
        .busy               (busy),
        .changeDone         (changeDone),
        .changeFail         (changeFail)
    );

    always #5 clk = ~clk;

    // RAM model: write on we, read data RD_LAT cycles after the address.
    logic [23:0] mem  [0:31];
    logic [23:0] pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (ram.RAM_we) mem[ram.RAM_addr] <= ram.RAM_wdata;
        pipe[0] <= mem[ram.RAM_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram.RAM_rdata = force_zero ? 24'h0 : pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {EV_WE, EV_DONE, EV_FAIL} ev_k_t;
    typedef struct {
        ev_k_t       k;
        int          cyc;
        logic [4:0]  addr;
        logic [23:0] wdata;
    } ev_t;
    ev_t exp_q[$];
    int  errors = 0, checks = 0;
    int  last_e;

    ev_t   m_e;
    ev_k_t m_k;
    bit    m_ok;
    // Monitor: every we/done/fail presented by the DUT must match the next expected event.
    always @(negedge clk) begin
        if (ram.RAM_we || changeDone || changeFail) begin
            m_k = ram.RAM_we ? EV_WE : (changeDone ? EV_DONE : EV_FAIL);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%s cyc=%0d addr=%0d wdata=%h required=none",
                         m_k.name(), cyc, ram.RAM_addr, ram.RAM_wdata);
            end else begin
                m_e  = exp_q.pop_front();
                m_ok = (m_e.k == m_k) && (m_e.cyc == cyc) &&
                       (m_k != EV_WE || (ram.RAM_addr == m_e.addr && ram.RAM_wdata == m_e.wdata));
                if (!m_ok) begin
                    errors++;
                    $display("FAIL event got=%s cyc=%0d addr=%0d wdata=%h required=%s cyc=%0d addr=%0d wdata=%h",
                             m_k.name(), cyc, ram.RAM_addr, ram.RAM_wdata,
                             m_e.k.name(), m_e.cyc, m_e.addr, m_e.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input ev_k_t k, input int c, input logic [4:0] a, input logic [23:0] w);
        ev_t e;
        e.k = k; e.cyc = c; e.addr = a; e.wdata = w;
        exp_q.push_back(e);
    endtask

    task automatic press_change();
        b_change = 1; tick(); b_change = 0;
    endtask

    // One digit pulse plus an idle gap; last_e is the edge that sampled it.
    task automatic digit_in(input logic [3:0] d);
        b_password = 1; digit = d; tick(); last_e = cyc; b_password = 0; tick();
    endtask

    task automatic enter6(input logic [23:0] w);
        for (int i = 0; i < 6; i++) digit_in(w[23-4*i -: 4]);
    endtask

    // Bounded wait for all expected events to be consumed.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        // Reset values.
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(ram.RAM_we), 0);
        chk("rst_done", 32'(changeDone), 0);
        chk("rst_fail", 32'(changeFail), 0);
        chk("rst_addr", 32'(ram.RAM_addr), 0);
        chk("rst_wdata", 32'(ram.RAM_wdata), 0);
        rst = 1; tick();

        // Successful change for player 3.
        loggedin = 1; pid = 3'd3;
        press_change();
        chk("busy_enter", 32'(busy), 1);
        enter6(24'h123456);
        enter6(24'h123456);
        push(EV_WE, last_e + 1, 5'd3, 24'h123456);
        push(EV_DONE, last_e + 7, 5'd0, 24'h0);
        chk("busy_write", 32'(busy), 1);
        drain("ok3");
        chk("busy_after_ok", 32'(busy), 0);

        // Confirm mismatch.
        press_change();
        enter6(24'h111111);
        enter6(24'h111112);
        push(EV_FAIL, last_e + 1, 5'd0, 24'h0);
        drain("mismatch");
        chk("busy_after_mismatch", 32'(busy), 0);

        // Refusals: guest, then logged out.
        isGuestIN = 1;
        press_change();
        push(EV_FAIL, cyc, 5'd0, 24'h0);
        chk("busy_guest", 32'(busy), 0);
        isGuestIN = 0; loggedin = 0; tick();
        press_change();
        push(EV_FAIL, cyc, 5'd0, 24'h0);
        chk("busy_loggedout", 32'(busy), 0);
        loggedin = 1;
        drain("refuse");

        // Non-BCD digits skipped; stray b_password in IDLE and b_change while busy ignored.
        pid = 3'd5;
        digit_in(4'd4);
        chk("idle_digit_busy", 32'(busy), 0);
        press_change();
        digit_in(4'd7); digit_in(4'hA); digit_in(4'd8); digit_in(4'd9);
        press_change(); tick();
        digit_in(4'd0); digit_in(4'd1); digit_in(4'd2);
        digit_in(4'd7); digit_in(4'd8); digit_in(4'd9); digit_in(4'd0);
        digit_in(4'hF); digit_in(4'd1); digit_in(4'd2);
        push(EV_WE, last_e + 1, 5'd5, 24'h789012);
        push(EV_DONE, last_e + 7, 5'd0, 24'h0);
        drain("filter");

        // Logout after the third confirm digit: silent abort.
        pid = 3'd2;
        press_change();
        enter6(24'h654321);
        digit_in(4'd6); digit_in(4'd5); digit_in(4'd4);
        loggedin = 0; tick();
        chk("busy_abort", 32'(busy), 0);
        loggedin = 1; tick(); tick();
        digit_in(4'd3); digit_in(4'd2); digit_in(4'd1);
        chk("busy_abort_late", 32'(busy), 0);
        drain("abort");

        // Readback returns zero: write happens, verify fails.
        force_zero = 1; pid = 3'd1;
        press_change();
        enter6(24'h246802);
        enter6(24'h246802);
        push(EV_WE, last_e + 1, 5'd1, 24'h246802);
        push(EV_FAIL, last_e + 7, 5'd0, 24'h0);
        drain("verify_zero");
        force_zero = 0;

        // Reset during the WRITE cycle.
        pid = 3'd6;
        press_change();
        enter6(24'h135790);
        enter6(24'h135790);
        push(EV_WE, last_e + 1, 5'd6, 24'h135790);
        rst = 0; tick();
        chk("wr_rst_we", 32'(ram.RAM_we), 0);
        chk("wr_rst_busy", 32'(busy), 0);
        chk("wr_rst_addr", 32'(ram.RAM_addr), 0);
        chk("wr_rst_wdata", 32'(ram.RAM_wdata), 0);
        chk("wr_rst_done", 32'(changeDone), 0);
        chk("wr_rst_fail", 32'(changeFail), 0);
        rst = 1;
        drain("write_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/password_updater.md
# password_updater

Lets a logged-in, non-guest player replace their 6-digit password. The player enters the new password, then enters it again to confirm. The block writes the new password into the password RAM at the player's internal ID, then reads it back to verify the write. It is the writer counterpart of the password checker, which reads the same RAM image, and it sits beside it in the controller.

## Interface
Parameters:
- RD_LAT, 3: cycles from address presented to RAM_rdata valid.
- ADDR_W, 5: password RAM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  one clock; reset is synchronous and active-low.
- loggedin  in  1  level from the checker; player session active.
- isGuestIN  in  1  guest session; guests may not change passwords.
- internalPlayerIDIN  in  3  current player's internal ID.
- b_change  in  1  single-cycle pulse; request a password change.
- b_password  in  1  single-cycle pulse; accept passwordDigit.
- passwordDigit  in  4  BCD digit; values above 9 are ignored.
- RAM_rdata  in  24  read data.
- RAM_addr  out  ADDR_W  RAM address.
- RAM_wdata  out  24  write data.
- RAM_we  out  1  write enable.
- busy  out  1  high in every state except IDLE.
- changeDone  out  1  one-cycle pulse on a verified write.
- changeFail  out  1  one-cycle pulse on mismatch, verify failure, or refusal.

## Operation
- Reset: state IDLE. All outputs 0: RAM_addr, RAM_wdata, RAM_we, busy, changeDone, changeFail. Internal newPass, confPass, playerID and digit counter are cleared.
- Digit order: digits are packed MSB-first, first digit into [23:20] and sixth into [3:0], the same packing the checker uses.
- IDLE:
  - b_change with loggedin=1 and isGuestIN=0: latch internalPlayerIDIN into playerID, clear newPass, confPass and digit count, go to ENTER_NEW.
  - b_change with loggedin=0 or isGuestIN=1: pulse changeFail, stay in IDLE.
- ENTER_NEW: each b_password with passwordDigit ≤ 9 shifts one digit into newPass and increments the count (0..5). After the 6th digit, clear the count and go to ENTER_CONF.
- ENTER_CONF: same digit handling into confPass. After the 6th digit, go to COMPARE.
- COMPARE:
  - newPass == confPass: go to WRITE.
  - Otherwise: pulse changeFail, go to IDLE. The RAM is untouched.
- WRITE:
  - RAM_addr = playerID, zero-extended.
  - RAM_wdata = newPass.
  - RAM_we = 1 for exactly this one cycle.
  - Go to RD_ADDR.
- RD_ADDR: RAM_we=0, RAM_addr held. A wait counter counts RD_LAT-1 cycles in RD_WAIT, then the block goes to RD_CATCH.
- RD_CATCH: capture RAM_rdata, go to VERIFY.
- VERIFY:
  - Captured value == newPass: pulse changeDone.
  - Otherwise: pulse changeFail.
  - Either way, go to IDLE.
- Abort: if loggedin falls in any non-IDLE state before WRITE, return to IDLE next cycle. No write occurs and no pulse is given. Once WRITE has issued, the sequence runs to completion regardless of loggedin.
- b_change while busy is ignored.
- b_password in IDLE is ignored.
- Digit pulses arriving in COMPARE through VERIFY are ignored.
- An unreachable state encoding returns to IDLE with reset output values.

## Timing
- All outputs are registered.
- RAM_we is high for exactly one cycle per successful compare.
- Latency from the 6th confirm digit pulse to changeDone: COMPARE(1) + WRITE(1) + RD_ADDR(1) + RD_WAIT(RD_LAT-1) + RD_CATCH(1) + VERIFY(1) = RD_LAT+4 cycles. With the default this is 7 cycles; changeDone is asserted on the 8th edge after the pulse.
- Latency from b_change to changeFail (refusal): 1 cycle.
- If reset is asserted mid-sequence, including the WRITE cycle, the block returns to IDLE at the next edge and RAM_we drops at that edge.

## Structure
- Shared controller package holds:
  - password width (24), digit count (6), RAM address width;
  - the state-encoding localparams.
- The checker uses the same package constants for packing.
- One sub-module is natural: pswd_digit_collector. It holds the 4-bit digit shift-in, the 0..5 counter, the ≤9 filter and a "full" flag, and is instantiated once. newPass and confPass are loaded from its output.
- The password RAM lives outside this block.

## Test plan
- Player ID 3 logged in, enters 1,2,3,4,5,6 twice → RAM_we one cycle with addr 3, wdata 0x123456. With the model RAM echoing, changeDone pulses 7 cycles after the last digit.
- New 111111, confirm 111112 → changeFail pulse, RAM_we never asserted, busy returns to 0.
- b_change with isGuestIN=1, and separately with loggedin=0 → changeFail one cycle later, busy stays 0.
- Digit 0xA inserted between valid digits → ignored. The stored word equals the six valid digits.
- loggedin drops after the third confirm digit → IDLE next cycle, no write, no pulse.
- RAM model returns 0x000000 on readback → changeFail after VERIFY, with RAM_we still asserted once. Also: rst=0 during WRITE → RAM_we 0 next edge and all outputs at reset values.
